// File: rtl/wb_mem_pkg.sv
// Shared types and helpers for the Wishbone slave memory.
//   state_t         : transaction FSM encoding (IDLE, WAIT, ACK)
//   WORD_W, BYTES   : data word width and byte lanes per word
//   addr_in_window  : true when a byte address falls inside base .. base+4*depth-1
package wb_mem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTES  = 4;

   // Unsigned subtraction: addresses below base wrap to a huge offset and fall outside.
   function automatic logic addr_in_window(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth);
      logic [31:0] off;
      off = addr - base;
      return off < 32'(depth * BYTES);
   endfunction

endpackage

// File: rtl/wb_bus.sv
// Wishbone classic bus bundle used between the SoC interconnect and memory slaves.
//   slave  modport : addr, wdata, sel, we, stb in; rdata, ack, err out
//   master modport : mirror image of slave
interface wb_bus;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  sel;
   logic        we;
   logic        stb;
   logic [31:0] rdata;
   logic        ack;
   logic        err;

   modport slave  (input addr, wdata, sel, we, stb, output rdata, ack, err);
   modport master (output addr, wdata, sel, we, stb, input rdata, ack, err);
endinterface

// File: rtl/wb_mem_array.sv
// Depth x 32-bit storage with a synchronous, enable-gated read register and an optional
// byte-enable write port. Every word powers up holding InitWord; contents survive reset.
// Build option: WB_MEMORY_WRITE_EN adds the write port (RAM); without it the array is ROM.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset, clears only the read register
//   re_i     : load rdata_o from word raddr_i at this edge
//   raddr_i  : read word index
//   we_i     : (RAM) write word waddr_i at this edge
//   waddr_i  : (RAM) write word index
//   wdata_i  : (RAM) write data
//   be_i     : (RAM) byte enables, be_i[i] covers wdata_i[8i+7:8i]
//   rdata_o  : read register, holds the last read word
module wb_mem_array
   import wb_mem_pkg::*;
#(
   parameter int unsigned    Depth    = 1024,
   parameter logic [31:0]    InitWord = 32'h0000_0013,
   localparam int unsigned   IdxW     = $clog2(Depth)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              re_i,
   input  logic [IdxW-1:0]   raddr_i,
`ifdef WB_MEMORY_WRITE_EN
   input  logic              we_i,
   input  logic [IdxW-1:0]   waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [BYTES-1:0]  be_i,
`endif
   output logic [WORD_W-1:0] rdata_o
);

   // Power-up fill; no reset path touches the storage.
   logic [WORD_W-1:0] mem_q [Depth] = '{default: InitWord};
   logic [WORD_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

`ifdef WB_MEMORY_WRITE_EN
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < BYTES; b++) begin
            if (be_i[b]) begin
               mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end
`endif

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_memory.sv
// Wishbone slave memory: word-addressed SRAM/ROM with configurable depth, base address and
// read latency. Boot ROM, instruction memory or data RAM for the core on the SoC bus.
// Build option: WB_MEMORY_WRITE_EN enables byte-select writes (RAM); otherwise any write
// request is answered with err and no write logic is elaborated (ROM).
// Ports:
//   clk_in    : sole clock, rising edge
//   reset_in  : synchronous active-high reset; drops any transaction in flight
//   bus_slave : Wishbone slave (addr, wdata, sel, we, stb in; rdata, ack, err out)
// Parameters: BaseAddr (byte address of word 0), Depth (words, power of two, 16..65536),
//   ReadLatency (1..4), InitWord (power-up word value), InitFile (preload image path, handed
//   to the implementation flow's memory initialisation; the fabric itself does not use it).
module wb_memory
   import wb_mem_pkg::*;
#(
   parameter logic [31:0]  BaseAddr    = 32'h0,
   parameter int unsigned  Depth       = 1024,
   parameter int unsigned  ReadLatency = 1,
   parameter logic [31:0]  InitWord    = 32'h0000_0013,
   parameter string        InitFile    = ""
) (
   input  logic  clk_in,
   input  logic  reset_in,
   wb_bus.slave  bus_slave
);

   localparam int unsigned IdxW = $clog2(Depth);

   state_t            state_q, state_d;
   logic [1:0]        lat_cnt_q, lat_cnt_d;
   logic              ack_q, ack_d;
   logic [IdxW-1:0]   idx_q, idx_d;

   logic [31:0]       local_addr;
   logic [IdxW-1:0]   idx;
   logic              err_c;
   logic              accept;
   logic              mem_re;
   logic [IdxW-1:0]   mem_raddr;
   logic [WORD_W-1:0] mem_rdata;

   assign local_addr = bus_slave.addr - BaseAddr;
   assign idx        = local_addr[IdxW+1:2];

   always_comb begin
      err_c = (bus_slave.addr[1:0] != 2'b00) | ~addr_in_window(bus_slave.addr, BaseAddr, Depth);
`ifdef WB_MEMORY_WRITE_EN
      err_c = err_c | (bus_slave.we & (bus_slave.sel == 4'b0000));
`else
      err_c = err_c | bus_slave.we;
`endif
   end

   assign accept = bus_slave.stb & ~err_c & (state_q == IDLE);

   // The array read is issued on the edge that enters ACK, so rdata only changes when a read
   // completes and an aborted read leaves it untouched.
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      idx_d     = idx_q;
      mem_re    = 1'b0;
      mem_raddr = idx;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               idx_d = idx;
               if (bus_slave.we) begin
                  state_d = ACK;
               end else if (ReadLatency == 1) begin
                  state_d = ACK;
                  mem_re  = 1'b1;
               end else begin
                  state_d   = WAIT;
                  lat_cnt_d = 2'(ReadLatency - 2);
               end
            end
         end
         WAIT: begin
            if (!bus_slave.stb) begin
               state_d = IDLE;
            end else if (lat_cnt_q == 2'd0) begin
               state_d   = ACK;
               mem_re    = 1'b1;
               mem_raddr = idx_q;
            end else begin
               lat_cnt_d = lat_cnt_q - 2'd1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ack_d = (state_d == ACK);
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q   <= IDLE;
         lat_cnt_q <= 2'd0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         ack_q     <= ack_d;
      end
   end

   always_ff @(posedge clk_in) begin
      idx_q <= idx_d;
   end

`ifdef WB_MEMORY_WRITE_EN
   logic mem_we;
   assign mem_we = accept & bus_slave.we;
`endif

   wb_mem_array #(
      .Depth    (Depth),
      .InitWord (InitWord)
   ) u_array (
      .clk_i    (clk_in),
      .rst_i    (reset_in),
      .re_i     (mem_re),
      .raddr_i  (mem_raddr),
`ifdef WB_MEMORY_WRITE_EN
      .we_i     (mem_we),
      .waddr_i  (idx),
      .wdata_i  (bus_slave.wdata),
      .be_i     (bus_slave.sel),
`endif
      .rdata_o  (mem_rdata)
   );

   assign bus_slave.rdata = mem_rdata;
   assign bus_slave.ack   = ack_q & bus_slave.stb;
   assign bus_slave.err   = bus_slave.stb & err_c & (state_q == IDLE);

   logic unused_sig;
`ifdef WB_MEMORY_WRITE_EN
   assign unused_sig = ^{local_addr[31:IdxW+2], local_addr[1:0], (InitFile != "")};
`else
   assign unused_sig = ^{local_addr[31:IdxW+2], local_addr[1:0], (InitFile != ""),
                         bus_slave.wdata, bus_slave.sel};
`endif

endmodule

// File: tb/tb_wb_memory.sv
// Bench for wb_memory: four instances with ReadLatency 1..4 sharing clock and reset, driven
// by directed and random transactions and checked against a word-array model of the memory.
module tb_wb_memory;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          DEPTH = 16;
   localparam logic [31:0] INIT  = 32'h0000_0013;
   localparam int          NDUT  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] addr_a  [NDUT];
   logic [31:0] wdata_a [NDUT];
   logic [3:0]  sel_a   [NDUT];
   logic        we_a    [NDUT];
   logic        stb_a   [NDUT];
   logic [31:0] rdata_a [NDUT];
   logic        ack_a   [NDUT];
   logic        err_a   [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      wb_bus bus ();
      assign bus.addr   = addr_a[g];
      assign bus.wdata  = wdata_a[g];
      assign bus.sel    = sel_a[g];
      assign bus.we     = we_a[g];
      assign bus.stb    = stb_a[g];
      assign rdata_a[g] = bus.rdata;
      assign ack_a[g]   = bus.ack;
      assign err_a[g]   = bus.err;

      wb_memory #(
         .BaseAddr    (BASE),
         .Depth       (DEPTH),
         .ReadLatency (g + 1),
         .InitWord    (INIT),
         .InitFile    ("")
      ) u_dut (
         .clk_in    (clk),
         .reset_in  (rst),
         .bus_slave (bus)
      );
   end

   // Reference model: plain word arrays plus the last completed read per instance.
   logic [31:0] model     [NDUT][DEPTH];
   logic [31:0] rdata_exp [NDUT];
   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic exp_err(input logic [31:0] a, input logic w, input logic [3:0] s);
      logic [31:0] off;
      logic bad;
      off = a - BASE;
      bad = (a[1:0] != 2'b00) || (off >= 32'(4 * DEPTH));
      if (w) begin
`ifdef WB_MEMORY_WRITE_EN
         bad = bad || (s == 4'b0000);
`else
         bad = 1'b1;
`endif
      end
      return bad;
   endfunction

   task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] s);
      int i;
      i = int'((a - BASE) >> 2);
      for (int b = 0; b < 4; b++) begin
         if (s[b]) model[d][i][8*b +: 8] = wd[8*b +: 8];
      end
   endtask

   // Starts at a falling edge with the instance idle, ends at a falling edge with it idle.
   task automatic txn(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] s);
      logic e;
      int   lat;
      e   = exp_err(a, w, s);
      lat = w ? 1 : d + 1;
      addr_a[d] = a; we_a[d] = w; wdata_a[d] = wd; sel_a[d] = s; stb_a[d] = 1'b1;
      #1;
      check("err", {31'b0, err_a[d]}, {31'b0, e});
      check("ack_early", {31'b0, ack_a[d]}, 32'd0);
      if (e) begin
         @(negedge clk);
         check("err_noack", {31'b0, ack_a[d]}, 32'd0);
         stb_a[d] = 1'b0;
      end else begin
         for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check("ack_cycle", {31'b0, ack_a[d]}, (k == lat) ? 32'd1 : 32'd0);
         end
         if (w) begin
            model_write(d, a, wd, s);
            check("rdata_hold", rdata_a[d], rdata_exp[d]);
         end else begin
            rdata_exp[d] = model[d][int'((a - BASE) >> 2)];
            check("rdata", rdata_a[d], rdata_exp[d]);
         end
         @(negedge clk);
         check("ack_once", {31'b0, ack_a[d]}, 32'd0);
         stb_a[d] = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] a;
      logic        w;
      int          d;
      for (int i = 0; i < NDUT; i++) begin
         addr_a[i] = '0; wdata_a[i] = '0; sel_a[i] = '0; we_a[i] = 1'b0; stb_a[i] = 1'b0;
         rdata_exp[i] = '0;
         for (int j = 0; j < DEPTH; j++) model[i][j] = INIT;
      end

      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
         check("reset_rdata", rdata_a[i], 32'd0);
         check("reset_ack", {31'b0, ack_a[i]}, 32'd0);
         check("reset_err", {31'b0, err_a[i]}, 32'd0);
      end

      // Reset while a latency-3 read sits in WAIT.
      addr_a[2] = BASE; we_a[2] = 1'b0; sel_a[2] = 4'hF; stb_a[2] = 1'b1;
      @(negedge clk);
      check("rst_pre_ack", {31'b0, ack_a[2]}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      stb_a[2] = 1'b0;
      #1;
      check("rst_mid_ack", {31'b0, ack_a[2]}, 32'd0);
      check("rst_mid_rdata", rdata_a[2], 32'd0);
      for (int i = 0; i < NDUT; i++) rdata_exp[i] = '0;
      @(negedge clk);
      txn(2, BASE, 1'b0, 32'd0, 4'hF);
      check("rst_reread", rdata_a[2], INIT);

      // Latency sweep.
      for (int i = 0; i < NDUT; i++) txn(i, BASE + 32'd8, 1'b0, 32'd0, 4'hF);

      // Byte writes.
      txn(0, BASE + 32'd16, 1'b1, 32'hDEAD_BEEF, 4'hF);
      txn(0, BASE + 32'd16, 1'b1, 32'h0000_00AA, 4'b0001);
      txn(0, BASE + 32'd16, 1'b0, 32'd0, 4'hF);
`ifdef WB_MEMORY_WRITE_EN
      check("byte_merge", rdata_a[0], 32'hDEAD_BEAA);
`else
      check("rom_keep", rdata_a[0], INIT);
`endif

      // Error cases, then confirm the word under the sel=0 write is untouched.
      txn(0, BASE + 32'd2, 1'b0, 32'd0, 4'hF);
      txn(0, BASE + 32'(4 * DEPTH), 1'b0, 32'd0, 4'hF);
      txn(0, BASE - 32'd4, 1'b0, 32'd0, 4'hF);
      txn(0, BASE + 32'd12, 1'b1, 32'hFFFF_FFFF, 4'h0);
      txn(0, BASE + 32'd12, 1'b0, 32'd0, 4'hF);

      // Write to word 0 of instance 1 (errors in a ROM build), then read it back.
      txn(1, BASE, 1'b1, 32'h1234_5678, 4'hF);
      txn(1, BASE, 1'b0, 32'd0, 4'hF);

      // Abort a latency-4 read in WAIT; the next request starts on the following idle cycle.
      addr_a[3] = BASE + 32'd4; we_a[3] = 1'b0; sel_a[3] = 4'hF; stb_a[3] = 1'b1;
      @(negedge clk);
      check("abort_ack", {31'b0, ack_a[3]}, 32'd0);
      stb_a[3] = 1'b0;
      @(negedge clk);
      check("abort_noack", {31'b0, ack_a[3]}, 32'd0);
      check("abort_rdata", rdata_a[3], rdata_exp[3]);
      txn(3, BASE + 32'd4, 1'b0, 32'd0, 4'hF);

      // Drop stb while in ACK: ack is masked, a write still lands.
      a = BASE + 32'd20;
      addr_a[0] = a; we_a[0] = 1'b1; wdata_a[0] = 32'h5555_AAAA; sel_a[0] = 4'hF;
      stb_a[0] = 1'b1;
      @(posedge clk);
      #1;
      stb_a[0] = 1'b0;
      @(negedge clk);
      check("ack_masked", {31'b0, ack_a[0]}, 32'd0);
      if (!exp_err(a, 1'b1, 4'hF)) model_write(0, a, 32'h5555_AAAA, 4'hF);
      @(negedge clk);
      txn(0, a, 1'b0, 32'd0, 4'hF);

      // Random traffic.
      for (int n = 0; n < 200; n++) begin
         d = int'($urandom_range(0, NDUT - 1));
         case ($urandom_range(0, 9))
            0:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            1:       a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         endcase
         w = 1'($urandom_range(0, 1));
         txn(d, a, w, $urandom, 4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
